// File: rtl/scpad_pkg.sv
// Shared scratchpad types: response beat layout, burst-table entry and
// the burst-membership test used on the return path.
package scpad_pkg;

    localparam int DRAM_ID_WIDTH   = 4;
    localparam int MAX_BURST_BEATS = 8;
    localparam int SCPAD_DATA_W    = 512;
    localparam int SCPAD_ADDR_W    = 10;

    typedef logic [SCPAD_DATA_W-1:0] scpad_data_t;

    typedef struct packed {
        logic [DRAM_ID_WIDTH-1:0] id;
        logic [2:0]               sub_id;
        scpad_data_t              data;
    } dram_resp_t;

    typedef struct packed {
        logic                    valid;
        logic [3:0]              remaining;
        logic [3:0]              total;
        logic [SCPAD_ADDR_W-1:0] base;
    } resp_tbl_entry_t;

    // A beat belongs to its burst when its index is below the latched length.
    function automatic logic beat_in_burst(input logic [2:0] sub_id, input logic [3:0] total);
        return ({1'b0, sub_id} < total);
    endfunction

endpackage

// File: rtl/scpad_sync_fifo.sv
// Single-clock FIFO with registered storage; the read port shows the head
// entry combinationally so a beat written at cycle N is visible at N+1.
module scpad_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next storage and pointer values; writes to a full FIFO are ignored.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Pointers reset to empty; storage contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/dram_resp_queue.sv
// DRAM read-response return path: buffers tagged beats, maps each legal beat
// to a scratchpad row write, and tracks per-id burst progress.
module dram_resp_queue
    import scpad_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ID_W   = DRAM_ID_WIDTH,
    parameter int DATA_W = SCPAD_DATA_W,
    parameter int ADDR_W = SCPAD_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ID_W-1:0]   alloc_id,
    input  logic [3:0]        alloc_num_request,
    input  logic [ADDR_W-1:0] alloc_base_addr,
    input  logic              dram_resp_valid,
    output logic              dram_resp_ready,
    input  logic [ID_W-1:0]   dram_resp_id,
    input  logic [2:0]        dram_resp_sub_id,
    input  logic [DATA_W-1:0] dram_resp_data,
    input  logic              sram_be_stall,
    output logic              sram_wr_valid,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              burst_complete,
    output logic [ID_W-1:0]   burst_complete_id,
    output logic              resp_queue_full,
    output logic              resp_err
);

    localparam int NUM_IDS = 2**ID_W;
    localparam int BEAT_W  = ID_W + 3 + DATA_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [2:0]        sub_id;
        logic [DATA_W-1:0] data;
    } resp_beat_t;

    typedef struct packed {
        logic [3:0]        remaining;
        logic [3:0]        total;
        logic [ADDR_W-1:0] base;
    } tbl_entry_t;

    logic [NUM_IDS-1:0] tbl_vld_q, tbl_vld_d;
    tbl_entry_t         tbl_q [NUM_IDS];
    tbl_entry_t         tbl_d [NUM_IDS];
    logic               burst_complete_q, burst_complete_d;
    logic [ID_W-1:0]    burst_complete_id_q, burst_complete_id_d;
    logic               resp_err_q, resp_err_d;

    resp_beat_t push_beat, head_beat;
    logic       fifo_full, fifo_empty, push, pop, head_legal;

    assign push_beat = '{id: dram_resp_id, sub_id: dram_resp_sub_id, data: dram_resp_data};
    assign push      = dram_resp_valid && !fifo_full;

    scpad_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (push),
        .wr_data (push_beat),
        .rd_en   (pop),
        .rd_data (head_beat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Illegal heads are discarded regardless of stall; legal heads wait for the backend.
    assign head_legal = !fifo_empty && tbl_vld_q[head_beat.id] &&
                        beat_in_burst(head_beat.sub_id, tbl_q[head_beat.id].total);
    assign pop        = !fifo_empty && (!head_legal || !sram_be_stall);

    assign sram_wr_valid     = head_legal;
    assign sram_wr_addr      = head_legal ? tbl_q[head_beat.id].base + ADDR_W'(head_beat.sub_id) : '0;
    assign sram_wr_data      = head_legal ? head_beat.data : '0;
    assign alloc_ready       = !tbl_vld_q[alloc_id];
    assign dram_resp_ready   = !fifo_full;
    assign resp_queue_full   = fifo_full;
    assign burst_complete    = burst_complete_q;
    assign burst_complete_id = burst_complete_id_q;
    assign resp_err          = resp_err_q;

    // Burst table update: allocation of a free slot and decrement on legal pop
    // never touch the same id because one needs the slot free, the other valid.
    always_comb begin
        tbl_vld_d           = tbl_vld_q;
        tbl_d               = tbl_q;
        burst_complete_d    = 1'b0;
        burst_complete_id_d = '0;
        resp_err_d          = 1'b0;
        if (alloc_valid && alloc_ready) begin
            if (alloc_num_request == 4'd0) begin
                resp_err_d = 1'b1;
            end else begin
                tbl_vld_d[alloc_id] = 1'b1;
                tbl_d[alloc_id]     = '{remaining: alloc_num_request,
                                        total:     alloc_num_request,
                                        base:      alloc_base_addr};
            end
        end
        if (pop) begin
            if (head_legal) begin
                tbl_d[head_beat.id].remaining = tbl_q[head_beat.id].remaining - 4'd1;
                if (tbl_q[head_beat.id].remaining == 4'd1) begin
                    tbl_vld_d[head_beat.id] = 1'b0;
                    burst_complete_d        = 1'b1;
                    burst_complete_id_d     = head_beat.id;
                end
            end else begin
                resp_err_d = 1'b1;
            end
        end
    end

    // Control state resets; table payload fields are only meaningful while valid.
    always_ff @(posedge CLK) begin
        tbl_q <= tbl_d;
        if (RST) begin
            tbl_vld_q           <= '0;
            burst_complete_q    <= 1'b0;
            burst_complete_id_q <= '0;
            resp_err_q          <= 1'b0;
        end else begin
            tbl_vld_q           <= tbl_vld_d;
            burst_complete_q    <= burst_complete_d;
            burst_complete_id_q <= burst_complete_id_d;
            resp_err_q          <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_dram_resp_queue.sv
// Directed bench for dram_resp_queue with a write/completion scoreboard.
module tb_dram_resp_queue;

    localparam int ID_W   = 4;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic [3:0]        alloc_num_request;
    logic [ADDR_W-1:0] alloc_base_addr;
    logic              dram_resp_valid;
    logic              dram_resp_ready;
    logic [ID_W-1:0]   dram_resp_id;
    logic [2:0]        dram_resp_sub_id;
    logic [DATA_W-1:0] dram_resp_data;
    logic              sram_be_stall;
    logic              sram_wr_valid;
    logic [ADDR_W-1:0] sram_wr_addr;
    logic [DATA_W-1:0] sram_wr_data;
    logic              burst_complete;
    logic [ID_W-1:0]   burst_complete_id;
    logic              resp_queue_full;
    logic              resp_err;

    always #5 CLK = ~CLK;

    dram_resp_queue #(
        .DEPTH (DEPTH), .ID_W (ID_W), .DATA_W (DATA_W), .ADDR_W (ADDR_W)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_id          (alloc_id),
        .alloc_num_request (alloc_num_request),
        .alloc_base_addr   (alloc_base_addr),
        .dram_resp_valid   (dram_resp_valid),
        .dram_resp_ready   (dram_resp_ready),
        .dram_resp_id      (dram_resp_id),
        .dram_resp_sub_id  (dram_resp_sub_id),
        .dram_resp_data    (dram_resp_data),
        .sram_be_stall     (sram_be_stall),
        .sram_wr_valid     (sram_wr_valid),
        .sram_wr_addr      (sram_wr_addr),
        .sram_wr_data      (sram_wr_data),
        .burst_complete    (burst_complete),
        .burst_complete_id (burst_complete_id),
        .resp_queue_full   (resp_queue_full),
        .resp_err          (resp_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    wr_exp_t         exp_q[$];
    logic [ID_W-1:0] cmp_exp_q[$];
    int              wr_cyc_log[$];
    int              cmp_cyc_log[$];
    int              cyc     = 0;
    int              err_cnt = 0;
    int              n_cmp   = 0;
    int              n_bad   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every accepted write and completion pulse is matched against the scoreboard.
    always @(negedge CLK) begin : monitor
        wr_exp_t         e;
        logic [ID_W-1:0] cid;
        if (!RST) begin
            if (sram_wr_valid && !sram_be_stall) begin
                wr_cyc_log.push_back(cyc);
                check_i("write_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_i("wr_addr", int'(sram_wr_addr), int'(e.addr));
                    check_w("wr_data", sram_wr_data, e.data);
                end
            end
            if (burst_complete) begin
                cmp_cyc_log.push_back(cyc);
                check_i("completion_expected", int'(cmp_exp_q.size() != 0), 1);
                if (cmp_exp_q.size() != 0) begin
                    cid = cmp_exp_q.pop_front();
                    check_i("burst_complete_id", int'(burst_complete_id), int'(cid));
                end
            end
            if (resp_err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_alloc(input logic [ID_W-1:0] id, input logic [3:0] n, input int base);
        bit ok;
        ok                = 1'b0;
        alloc_valid       = 1'b1;
        alloc_id          = id;
        alloc_num_request = n;
        alloc_base_addr   = ADDR_W'(base);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (alloc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_i("alloc_wait", int'(ok), 1);
        tick();
        alloc_valid = 1'b0;
    endtask

    // Drives one beat until accepted; acc_cyc is the cycle the beat becomes head.
    task automatic push_beat(input logic [ID_W-1:0] id, input logic [2:0] sub, input int addr,
                             input bit expect_write, output int acc_cyc);
        logic [DATA_W-1:0] d;
        bit ok;
        ok               = 1'b0;
        d                = rand_data();
        dram_resp_valid  = 1'b1;
        dram_resp_id     = id;
        dram_resp_sub_id = sub;
        dram_resp_data   = d;
        if (expect_write) exp_q.push_back('{addr: ADDR_W'(addr), data: d});
        acc_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (dram_resp_ready) begin
                ok = 1'b1;
                acc_cyc = cyc + 1;
                break;
            end
        end
        check_i("push_wait", int'(ok), 1);
        tick();
        dram_resp_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && cmp_exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_i("drain_wait", int'(ok), 1);
        tick();
        tick();
    endtask

    initial begin : stim
        int c, c0, wb, cb, e0, rel;
        RST               = 1'b1;
        alloc_valid       = 1'b0;
        alloc_id          = '0;
        alloc_num_request = '0;
        alloc_base_addr   = '0;
        dram_resp_valid   = 1'b0;
        dram_resp_id      = '0;
        dram_resp_sub_id  = '0;
        dram_resp_data    = '0;
        sram_be_stall     = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check_i("rst_wr_valid", int'(sram_wr_valid), 0);
        check_i("rst_wr_addr", int'(sram_wr_addr), 0);
        check_w("rst_wr_data", sram_wr_data, '0);
        check_i("rst_complete", int'(burst_complete), 0);
        check_i("rst_err", int'(resp_err), 0);
        check_i("rst_full", int'(resp_queue_full), 0);
        check_i("rst_resp_ready", int'(dram_resp_ready), 1);
        check_i("rst_alloc_ready", int'(alloc_ready), 1);
        tick();

        // Back-to-back burst: writes on consecutive cycles, completion one cycle after the last.
        do_alloc(4'd3, 4'd4, 'h100);
        wb = wr_cyc_log.size();
        cb = cmp_cyc_log.size();
        cmp_exp_q.push_back(4'd3);
        c0 = 0;
        for (int s = 0; s < 4; s++) begin
            push_beat(4'd3, 3'(s), 'h100 + s, 1'b1, c);
            if (s == 0) c0 = c;
        end
        drain();
        check_i("t1_first_write_cyc", wr_cyc_log[wb], c0);
        check_i("t1_last_write_cyc", wr_cyc_log[wb+3], c0 + 3);
        check_i("t1_complete_cyc", cmp_cyc_log[cb], c0 + 4);
        check_i("t1_one_pulse", cmp_cyc_log.size(), cb + 1);

        // Out-of-order sub_ids with address wrap.
        do_alloc(4'd5, 4'd3, 'h3FE);
        cb = cmp_cyc_log.size();
        cmp_exp_q.push_back(4'd5);
        push_beat(4'd5, 3'd2, 'h3FE + 2, 1'b1, c);
        push_beat(4'd5, 3'd0, 'h3FE, 1'b1, c);
        push_beat(4'd5, 3'd1, 'h3FE + 1, 1'b1, c);
        drain();
        check_i("t2_one_pulse", cmp_cyc_log.size(), cb + 1);

        // Fill under stall, reject a ninth beat, then drain at full rate.
        do_alloc(4'd1, 4'd8, 'h040);
        sram_be_stall = 1'b1;
        wb = wr_cyc_log.size();
        e0 = err_cnt;
        cmp_exp_q.push_back(4'd1);
        for (int s = 0; s < 8; s++) push_beat(4'd1, 3'(s), 'h040 + s, 1'b1, c);
        @(negedge CLK);
        check_i("t3_full", int'(resp_queue_full), 1);
        check_i("t3_ready_low", int'(dram_resp_ready), 0);
        dram_resp_valid  = 1'b1;
        dram_resp_id     = 4'd1;
        dram_resp_sub_id = 3'd0;
        dram_resp_data   = rand_data();
        repeat (3) tick();
        @(negedge CLK);
        check_i("t3_ninth_rejected", int'(dram_resp_ready), 0);
        tick();
        dram_resp_valid = 1'b0;
        sram_be_stall   = 1'b0;
        rel = cyc;
        @(negedge CLK);
        check_i("t3_ready_before_pop", int'(dram_resp_ready), 0);
        @(negedge CLK);
        check_i("t3_ready_after_pop", int'(dram_resp_ready), 1);
        drain();
        check_i("t3_first_write_cyc", wr_cyc_log[wb], rel);
        check_i("t3_last_write_cyc", wr_cyc_log[wb+7], rel + 7);
        check_i("t3_no_err", err_cnt - e0, 0);

        // Unallocated id and out-of-range sub_id are dropped without decrementing.
        e0 = err_cnt;
        do_alloc(4'd3, 4'd4, 'h200);
        push_beat(4'd7, 3'd0, 0, 1'b0, c);
        push_beat(4'd3, 3'd5, 0, 1'b0, c);
        repeat (4) tick();
        check_i("t4_two_errs", err_cnt - e0, 2);
        do_alloc(4'd9, 4'd0, 'h000);
        repeat (3) tick();
        check_i("t4_zero_alloc_err", err_cnt - e0, 3);
        alloc_id = 4'd9;
        @(negedge CLK);
        check_i("t4_zero_alloc_no_state", int'(alloc_ready), 1);
        tick();
        cb = cmp_cyc_log.size();
        cmp_exp_q.push_back(4'd3);
        c0 = 0;
        for (int s = 0; s < 4; s++) begin
            push_beat(4'd3, 3'(s), 'h200 + s, 1'b1, c);
            if (s == 0) c0 = c;
        end
        drain();
        check_i("t4_no_decrement", cmp_cyc_log[cb], c0 + 4);

        // Re-allocating an id in the cycle its last beat pops is deferred one cycle.
        do_alloc(4'd2, 4'd1, 'h010);
        cb = cmp_cyc_log.size();
        cmp_exp_q.push_back(4'd2);
        push_beat(4'd2, 3'd0, 'h010, 1'b1, c);
        alloc_valid       = 1'b1;
        alloc_id          = 4'd2;
        alloc_num_request = 4'd2;
        alloc_base_addr   = 10'h020;
        @(negedge CLK);
        check_i("t5_final_pop_write", int'(sram_wr_valid), 1);
        check_i("t5_alloc_blocked", int'(alloc_ready), 0);
        tick();
        @(negedge CLK);
        check_i("t5_alloc_open", int'(alloc_ready), 1);
        tick();
        alloc_valid = 1'b0;
        cmp_exp_q.push_back(4'd2);
        push_beat(4'd2, 3'd1, 'h021, 1'b1, c);
        push_beat(4'd2, 3'd0, 'h020, 1'b1, c);
        drain();
        check_i("t5_two_pulses", cmp_cyc_log.size(), cb + 2);

        // Reset with buffered beats and open bursts discards everything.
        do_alloc(4'd4, 4'd4, 'h080);
        do_alloc(4'd6, 4'd2, 'h0C0);
        sram_be_stall = 1'b1;
        push_beat(4'd4, 3'd0, 0, 1'b0, c);
        push_beat(4'd4, 3'd1, 0, 1'b0, c);
        push_beat(4'd6, 3'd0, 0, 1'b0, c);
        e0 = err_cnt;
        RST = 1'b1;
        tick();
        RST           = 1'b0;
        sram_be_stall = 1'b0;
        alloc_id      = 4'd4;
        wb = wr_cyc_log.size();
        cb = cmp_cyc_log.size();
        @(negedge CLK);
        check_i("t6_resp_ready", int'(dram_resp_ready), 1);
        check_i("t6_not_full", int'(resp_queue_full), 0);
        check_i("t6_wr_valid", int'(sram_wr_valid), 0);
        check_i("t6_complete", int'(burst_complete), 0);
        check_i("t6_alloc_ready", int'(alloc_ready), 1);
        alloc_id = 4'd6;
        @(negedge CLK);
        check_i("t6_alloc_ready_6", int'(alloc_ready), 1);
        repeat (4) tick();
        check_i("t6_no_writes", wr_cyc_log.size(), wb);
        check_i("t6_no_pulses", cmp_cyc_log.size(), cb);
        check_i("t6_no_errs", err_cnt - e0, 0);
        do_alloc(4'd4, 4'd1, 'h0F0);
        cmp_exp_q.push_back(4'd4);
        push_beat(4'd4, 3'd0, 'h0F0, 1'b1, c);
        drain();

        check_i("end_wr_scoreboard_empty", exp_q.size(), 0);
        check_i("end_cmp_scoreboard_empty", cmp_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
